cache_way_controller: RTL and testbench

CACHE_WAY_CONTROLLER -- requirements
Module: cache_way_controller

---
 rtl/cache_way_controller.sv | 184 ++++++++++++++++++
 tb/tb_cache_way_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_way_controller.sv
// Set-associative cache way controller: MESI tag/state lookup, round-robin victim choice,
// writeback/fill sequencing. Optional hit/miss statistics under the STATS_EN macro.
module cache_way_controller #(
  parameter int unsigned i_size   = 16,
  parameter int unsigned c_size   = 10,
  parameter int unsigned d_size   = 4,
  parameter int unsigned a_size   = 4,
  parameter int unsigned protocol = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_op,
  input  logic [i_size-1:0]         req_addr,
  output logic                      resp_valid,
  output logic                      resp_hit,
  output logic [$clog2(a_size)-1:0] resp_way,
  output logic                      mem_valid,
  output logic                      mem_write,
  output logic [i_size-1:0]         mem_addr,
  input  logic                      mem_ack
`ifdef STATS_EN
  ,
  output logic [15:0]               hit_count,
  output logic [15:0]               miss_count
`endif
);

  localparam int unsigned way_w  = $clog2(a_size);
  localparam int unsigned idx_w  = c_size - d_size - way_w;
  localparam int unsigned tag_w  = i_size - idx_w - d_size;
  localparam int unsigned n_sets = 2 ** idx_w;

  localparam logic [protocol-1:0] MESI_I = protocol'(0);
  localparam logic [protocol-1:0] MESI_E = protocol'(2);
  localparam logic [protocol-1:0] MESI_M = protocol'(3);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;

  state_t state, state_n;

  logic [n_sets-1:0][a_size-1:0][tag_w-1:0]    tag_mem;
  logic [n_sets-1:0][a_size-1:0][protocol-1:0] mesi_mem;
  logic [n_sets-1:0][way_w-1:0]                rr_ptr;

  logic             op_q;
  logic [tag_w-1:0] tag_q;
  logic [idx_w-1:0] idx_q;
  logic             hit_q;
  logic [way_w-1:0] way_q;

  logic              hit_c, inv_c, by_ptr_c;
  logic [way_w-1:0]  hit_way_c, inv_way_c, victim_c, sel_way;
  logic [i_size-1:0] mem_addr_n;

  // Offset bits of the request never affect line-granular behaviour.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[d_size-1:0];

  // Tag compare and victim selection for the captured request's set.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    inv_c     = 1'b0;
    inv_way_c = '0;
    for (int w = 0; w < int'(a_size); w++) begin
      if (!hit_c && mesi_mem[idx_q][way_w'(w)] != MESI_I &&
          tag_mem[idx_q][way_w'(w)] == tag_q) begin
        hit_c     = 1'b1;
        hit_way_c = way_w'(w);
      end
      if (!inv_c && mesi_mem[idx_q][way_w'(w)] == MESI_I) begin
        inv_c     = 1'b1;
        inv_way_c = way_w'(w);
      end
    end
    by_ptr_c = !inv_c;
    victim_c = inv_c ? inv_way_c : rr_ptr[idx_q];
  end

  // Next state and next registered memory address.
  always_comb begin
    state_n    = state;
    mem_addr_n = '0;
    sel_way    = (state == LOOKUP) ? victim_c : way_q;
    case (state)
      IDLE:    if (req_valid) state_n = LOOKUP;
      LOOKUP: begin
        if (hit_c)                                  state_n = RESP;
        else if (mesi_mem[idx_q][victim_c] == MESI_M) state_n = WB;
        else                                        state_n = FILL;
      end
      WB:      if (mem_ack) state_n = FILL;
      FILL:    if (mem_ack) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    case (state_n)
      WB:      mem_addr_n = {tag_mem[idx_q][sel_way], idx_q, {d_size{1'b0}}};
      FILL:    mem_addr_n = {tag_q, idx_q, {d_size{1'b0}}};
      default: mem_addr_n = '0;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_way   <= '0;
      mem_valid  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state      <= state_n;
      req_ready  <= (state_n == IDLE);
      resp_valid <= (state == RESP);
      resp_hit   <= (state == RESP) && hit_q;
      resp_way   <= (state == RESP) ? way_q : '0;
      mem_valid  <= (state_n == WB) || (state_n == FILL);
      mem_write  <= (state_n == WB);
      mem_addr   <= mem_addr_n;
    end
  end

  // Request capture and lookup result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= 1'b0;
      tag_q <= '0;
      idx_q <= '0;
      hit_q <= 1'b0;
      way_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q  <= req_op;
        tag_q <= req_addr[i_size-1 -: tag_w];
        idx_q <= req_addr[d_size +: idx_w];
      end
      if (state == LOOKUP) begin
        hit_q <= hit_c;
        way_q <= hit_c ? hit_way_c : victim_c;
      end
    end
  end

  // Tag, MESI and round-robin pointer arrays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_mem  <= '0;
      mesi_mem <= '0;
      rr_ptr   <= '0;
    end else begin
      if (state == LOOKUP) begin
        if (hit_c && op_q)     mesi_mem[idx_q][hit_way_c] <= MESI_M;
        if (!hit_c && by_ptr_c) rr_ptr[idx_q] <= rr_ptr[idx_q] + way_w'(1);
      end
      if (state == FILL && mem_ack) begin
        tag_mem[idx_q][way_q]  <= tag_q;
        mesi_mem[idx_q][way_q] <= op_q ? MESI_M : MESI_E;
      end
    end
  end

`ifdef STATS_EN
  // Saturating hit/miss counters, one step per completed request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == RESP) begin
      if (hit_q) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_way_controller.sv
// Directed self-checking bench for cache_way_controller (default geometry: 4 ways, 16 sets, 16B lines).
module tb_cache_way_controller;

  logic        clk, rst;
  logic        req_valid, req_ready, req_op;
  logic [15:0] req_addr;
  logic        resp_valid, resp_hit;
  logic [1:0]  resp_way;
  logic        mem_valid, mem_write, mem_ack;
  logic [15:0] mem_addr;
`ifdef STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int total = 0;
  int passed = 0;

  logic        got, wr, stable, va, hit, saw;
  logic [15:0] ma, maa;
  logic [1:0]  way;
  int          cyc;

  cache_way_controller dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr), .mem_ack(mem_ack)
`ifdef STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_req(input logic op, input logic [15:0] addr);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic mem_phase(output logic g, output logic w, output logic [15:0] a,
                           output logic st, output logic v_after, output logic [15:0] a_after);
    g = 0; w = 0; a = '0; st = 1; v_after = 0; a_after = '0;
    for (int i = 0; i < 20 && !g; i++) begin
      @(posedge clk); #1;
      if (mem_valid) g = 1;
    end
    if (g) begin
      w = mem_write; a = mem_addr;
      repeat (2) begin
        @(posedge clk); #1;
        if (!mem_valid || mem_write !== w || mem_addr !== a) st = 0;
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      v_after = mem_valid; a_after = mem_addr;
    end
  endtask

  task automatic get_resp(output logic g, output int c, output logic h, output logic [1:0] wy,
                          output logic sm);
    g = 0; c = 0; h = 0; wy = '0; sm = 0;
    for (int i = 0; i < 20 && !g; i++) begin
      @(posedge clk); #1;
      c = i + 1;
      if (mem_valid) sm = 1;
      if (resp_valid) begin g = 1; h = resp_hit; wy = resp_way; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else passed++;
    total++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b want 0", mem_valid); else passed++;
    total++; if (mem_addr !== 16'h0) $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_read_miss;
    send_req(1'b0, 16'h1230);
    total++; if (req_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", req_ready); else passed++;
    mem_phase(got, wr, ma, stable, va, maa);
    total++; if (got !== 1'b1) $display("FAIL miss_fill_seen: got %b want 1", got); else passed++;
    total++; if (wr !== 1'b0) $display("FAIL miss_fill_write: got %b want 0", wr); else passed++;
    total++; if (ma !== 16'h1230) $display("FAIL miss_fill_addr: got %h want 1230", ma); else passed++;
    total++; if (stable !== 1'b1) $display("FAIL miss_fill_stable: got %b want 1", stable); else passed++;
    total++; if (va !== 1'b0) $display("FAIL miss_fill_drop: got %b want 0", va); else passed++;
    get_resp(got, cyc, hit, way, saw);
    total++; if (got !== 1'b1) $display("FAIL miss_resp_seen: got %b want 1", got); else passed++;
    total++; if (hit !== 1'b0) $display("FAIL miss_resp_hit: got %b want 0", hit); else passed++;
    total++; if (way !== 2'd0) $display("FAIL miss_resp_way: got %0d want 0", way); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL miss_ready_back: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_read_hit;
    send_req(1'b0, 16'h1234);
    get_resp(got, cyc, hit, way, saw);
    total++; if (cyc !== 2) $display("FAIL hit_latency: got %0d want 2", cyc); else passed++;
    total++; if (hit !== 1'b1) $display("FAIL hit_resp_hit: got %b want 1", hit); else passed++;
    total++; if (way !== 2'd0) $display("FAIL hit_resp_way: got %0d want 0", way); else passed++;
    total++; if (saw !== 1'b0) $display("FAIL hit_no_mem: got %b want 0", saw); else passed++;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL hit_pulse_len: got %b want 0", resp_valid); else passed++;
`ifdef STATS_EN
    total++; if (hit_count !== 16'd1) $display("FAIL stat_hits: got %0d want 1", hit_count); else passed++;
    total++; if (miss_count !== 16'd1) $display("FAIL stat_misses: got %0d want 1", miss_count); else passed++;
`endif
  endtask

  task automatic test_rr_writeback;
    send_req(1'b1, 16'h1234);
    get_resp(got, cyc, hit, way, saw);
    total++; if (hit !== 1'b1 || cyc !== 2) $display("FAIL wr_hit: got hit=%b cyc=%0d want hit=1 cyc=2", hit, cyc); else passed++;
    for (int i = 1; i <= 3; i++) begin
      send_req(1'b0, 16'h0030 + 16'(i - 1) * 16'h0100);
      mem_phase(got, wr, ma, stable, va, maa);
      total++; if (ma !== 16'h0030 + 16'(i - 1) * 16'h0100 || wr !== 1'b0)
        $display("FAIL fill_way%0d: got addr=%h wr=%b", i, ma, wr); else passed++;
      get_resp(got, cyc, hit, way, saw);
      total++; if (way !== 2'(i) || hit !== 1'b0)
        $display("FAIL fill_way%0d_resp: got way=%0d hit=%b want way=%0d hit=0", i, way, hit, i); else passed++;
    end
    send_req(1'b0, 16'h0330);
    mem_phase(got, wr, ma, stable, va, maa);
    total++; if (wr !== 1'b1) $display("FAIL wb_write: got %b want 1", wr); else passed++;
    total++; if (ma !== 16'h1230) $display("FAIL wb_addr: got %h want 1230", ma); else passed++;
    total++; if (stable !== 1'b1) $display("FAIL wb_stable: got %b want 1", stable); else passed++;
    total++; if (va !== 1'b1 || maa !== 16'h0330) $display("FAIL wb_to_fill: got valid=%b addr=%h want 1 0330", va, maa); else passed++;
    mem_phase(got, wr, ma, stable, va, maa);
    total++; if (wr !== 1'b0 || ma !== 16'h0330) $display("FAIL wb_fill: got wr=%b addr=%h want 0 0330", wr, ma); else passed++;
    get_resp(got, cyc, hit, way, saw);
    total++; if (way !== 2'd0 || hit !== 1'b0) $display("FAIL wb_resp: got way=%0d hit=%b want 0 0", way, hit); else passed++;
    // Pointer now 1: next full-set miss evicts clean way 1 without writeback.
    send_req(1'b0, 16'h0430);
    mem_phase(got, wr, ma, stable, va, maa);
    total++; if (wr !== 1'b0 || ma !== 16'h0430) $display("FAIL rr_fill: got wr=%b addr=%h want 0 0430", wr, ma); else passed++;
    get_resp(got, cyc, hit, way, saw);
    total++; if (way !== 2'd1) $display("FAIL rr_ptr_way: got %0d want 1", way); else passed++;
    send_req(1'b0, 16'h0338);
    get_resp(got, cyc, hit, way, saw);
    total++; if (hit !== 1'b1 || way !== 2'd0) $display("FAIL refill_hit: got hit=%b way=%0d want 1 0", hit, way); else passed++;
  endtask

  task automatic test_reset_during_wb;
    int pulses;
    send_req(1'b1, 16'h0130);
    get_resp(got, cyc, hit, way, saw);
    total++; if (hit !== 1'b1 || way !== 2'd2) $display("FAIL wr_hit_way2: got hit=%b way=%0d want 1 2", hit, way); else passed++;
    send_req(1'b0, 16'h0530);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (mem_valid) got = 1;
    end
    total++; if (got !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 16'h0130)
      $display("FAIL wb2: got seen=%b wr=%b addr=%h want 1 1 0130", got, mem_write, mem_addr); else passed++;
    rst = 1'b1;
    #1;
    total++; if (mem_valid !== 1'b0) $display("FAIL rst_async_mem: got %b want 0", mem_valid); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", req_ready); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL rst_abandon: got %0d responses want 0", pulses); else passed++;
    send_req(1'b0, 16'h1230);
    mem_phase(got, wr, ma, stable, va, maa);
    total++; if (got !== 1'b1 || ma !== 16'h1230) $display("FAIL post_rst_miss: got seen=%b addr=%h want 1 1230", got, ma); else passed++;
    get_resp(got, cyc, hit, way, saw);
    total++; if (hit !== 1'b0 || way !== 2'd0) $display("FAIL post_rst_resp: got hit=%b way=%0d want 0 0", hit, way); else passed++;
  endtask

  task automatic test_busy_ignore;
    int pulses, mems;
    send_req(1'b0, 16'h2270);
    req_valid = 1'b1; req_op = 1'b0; req_addr = 16'h3370;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (mem_valid) got = 1;
    end
    total++; if (got !== 1'b1 || mem_addr !== 16'h2270) $display("FAIL busy_fill: got seen=%b addr=%h want 1 2270", got, mem_addr); else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b0) $display("FAIL busy_not_ready: got %b want 0", req_ready); else passed++;
    mem_ack = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    pulses = 0; mems = 0; hit = 1'b1; way = 2'd3;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_valid) mems++;
      if (resp_valid) begin pulses++; hit = resp_hit; way = resp_way; end
    end
    total++; if (pulses !== 1) $display("FAIL busy_one_resp: got %0d want 1", pulses); else passed++;
    total++; if (mems !== 0) $display("FAIL busy_no_second: got %0d mem cycles want 0", mems); else passed++;
    total++; if (hit !== 1'b0 || way !== 2'd0) $display("FAIL busy_resp: got hit=%b way=%0d want 0 0", hit, way); else passed++;
    send_req(1'b0, 16'h3370);
    mem_phase(got, wr, ma, stable, va, maa);
    get_resp(got, cyc, hit, way, saw);
    total++; if (hit !== 1'b0 || way !== 2'd1) $display("FAIL ignored_req_miss: got hit=%b way=%0d want 0 1", hit, way); else passed++;
  endtask

  task automatic test_write_miss;
    send_req(1'b1, 16'h4480);
    mem_phase(got, wr, ma, stable, va, maa);
    total++; if (wr !== 1'b0 || ma !== 16'h4480) $display("FAIL wmiss_fill: got wr=%b addr=%h want 0 4480", wr, ma); else passed++;
    get_resp(got, cyc, hit, way, saw);
    for (int i = 1; i <= 3; i++) begin
      send_req(1'b0, 16'h4480 + 16'(i) * 16'h0100);
      mem_phase(got, wr, ma, stable, va, maa);
      get_resp(got, cyc, hit, way, saw);
    end
    total++; if (way !== 2'd3) $display("FAIL wmiss_set_full: got %0d want 3", way); else passed++;
    send_req(1'b0, 16'h4880);
    mem_phase(got, wr, ma, stable, va, maa);
    total++; if (wr !== 1'b1 || ma !== 16'h4480) $display("FAIL wmiss_dirty_wb: got wr=%b addr=%h want 1 4480", wr, ma); else passed++;
    mem_phase(got, wr, ma, stable, va, maa);
    get_resp(got, cyc, hit, way, saw);
    total++; if (way !== 2'd0 || hit !== 1'b0) $display("FAIL wmiss_evict_resp: got way=%0d hit=%b want 0 0", way, hit); else passed++;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_addr = '0; mem_ack = 1'b0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_rr_writeback();
    test_reset_during_wb();
    test_busy_ignore();
    test_write_miss();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
